// File: rtl/dual_port_tx_ram_be_pkg.sv
// Shared types and byte-lane helpers for the dual-port TX buffer RAM.
// Lane merging is done at a fixed maximum width; callers zero-extend and truncate.
package dpram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BE_W           = DATA_WIDTH_DEF / 8;
  localparam int MERGE_DW       = 256;
  localparam int MERGE_BW       = MERGE_DW / 8;

  function automatic logic [MERGE_DW-1:0] be_merge(
    input logic [MERGE_DW-1:0] old_word,
    input logic [MERGE_DW-1:0] new_word,
    input logic [MERGE_BW-1:0] be
  );
    logic [MERGE_DW-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BW; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_word[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dual_port_tx_ram_be_if.sv
// Port bundle for the dual-port TX buffer RAM: two request/response ports plus status.
interface dual_port_tx_ram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  a_en;
  logic                  a_we;
  logic [LANES-1:0]      a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvalid;
  logic                  a_err;

  logic                  b_en;
  logic                  b_we;
  logic [LANES-1:0]      b_be;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_rvalid;
  logic                  b_err;

  logic                  collision;
  logic                  init_busy;

  modport master (
    output a_en, a_we, a_be, a_addr, a_wdata,
    output b_en, b_we, b_be, b_addr, b_wdata,
    input  a_rdata, a_rvalid, a_err,
    input  b_rdata, b_rvalid, b_err,
    input  collision, init_busy
  );

  modport slave (
    input  a_en, a_we, a_be, a_addr, a_wdata,
    input  b_en, b_we, b_be, b_addr, b_wdata,
    output a_rdata, a_rvalid, a_err,
    output b_rdata, b_rvalid, b_err,
    output collision, init_busy
  );

endinterface

// File: rtl/dual_port_tx_ram_be_rd_pipe.sv
// Per-port read return pipe carrying {rvalid, err, rdata}; rdata holds between reads.
module dpram_rd_pipe
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  vld1_r;
  logic                  err1_r;
  logic [DATA_WIDTH-1:0] dat1_r;

  // First stage: capture request result, keep data when no read returns
  always_ff @(posedge clk) begin
    if (reset) begin
      vld1_r <= 1'b0;
      err1_r <= 1'b0;
      dat1_r <= {DATA_WIDTH{1'b0}};
    end else begin
      vld1_r <= in_valid;
      err1_r <= in_err;
      if (in_valid) begin
        dat1_r <= in_data;
      end else begin
        dat1_r <= dat1_r;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  vld2_r;
      logic                  err2_r;
      logic [DATA_WIDTH-1:0] dat2_r;

      // Optional output register stage
      always_ff @(posedge clk) begin
        if (reset) begin
          vld2_r <= 1'b0;
          err2_r <= 1'b0;
          dat2_r <= {DATA_WIDTH{1'b0}};
        end else begin
          vld2_r <= vld1_r;
          err2_r <= err1_r;
          if (vld1_r) begin
            dat2_r <= dat1_r;
          end else begin
            dat2_r <= dat2_r;
          end
        end
      end

      assign out_valid = vld2_r;
      assign out_err   = err2_r;
      assign out_data  = dat2_r;
    end else begin : g_lat1
      assign out_valid = vld1_r;
      assign out_err   = err1_r;
      assign out_data  = dat1_r;
    end
  endgenerate

endmodule

// File: rtl/dual_port_tx_ram_be.sv
// True dual-port TX buffer RAM with byte enables, collision resolution,
// configurable read latency and a post-reset clear sequencer.
module dual_port_tx_ram_be
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  parameter int PRIORITY_A = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  dual_port_tx_ram_be_if.slave  bus
);

  localparam int                  LANES     = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  collision_r;

  logic                  a_req, b_req, a_inr, b_inr;
  logic                  a_wr, b_wr, a_rd, b_rd, a_oor, b_oor;
  logic                  same_addr, both_wr, overlap;
  logic [ADDR_WIDTH-1:0] a_idx, b_idx;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_word, b_word, both_word;
  logic [DATA_WIDTH-1:0] a_rd_word, b_rd_word;

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      be
  );
    logic [MERGE_DW-1:0] res;
    res = be_merge(MERGE_DW'(old_word), MERGE_DW'(new_word), MERGE_BW'(be));
    return res[DATA_WIDTH-1:0];
  endfunction

  // Request decode, lane merging and read-during-write selection
  always_comb begin
    a_req     = bus.a_en & (state == IDLE);
    b_req     = bus.b_en & (state == IDLE);
    a_inr     = ({1'b0, bus.a_addr} < DEPTH_W);
    b_inr     = ({1'b0, bus.b_addr} < DEPTH_W);
    // Out-of-range requests must never touch the array; park the index on word 0.
    a_idx     = a_inr ? bus.a_addr : {ADDR_WIDTH{1'b0}};
    b_idx     = b_inr ? bus.b_addr : {ADDR_WIDTH{1'b0}};
    a_wr      = a_req & bus.a_we & a_inr;
    b_wr      = b_req & bus.b_we & b_inr;
    a_rd      = a_req & ~bus.a_we;
    b_rd      = b_req & ~bus.b_we;
    a_oor     = a_req & ~a_inr;
    b_oor     = b_req & ~b_inr;
    same_addr = (bus.a_addr == bus.b_addr);
    both_wr   = a_wr & b_wr & same_addr;
    overlap   = both_wr & (|(bus.a_be & bus.b_be));
    a_old     = mem[a_idx];
    b_old     = mem[b_idx];
    a_word    = merge_word(a_old, bus.a_wdata, bus.a_be);
    b_word    = merge_word(b_old, bus.b_wdata, bus.b_be);
    // Winner's lanes are applied last so they override the loser on overlap.
    if (PRIORITY_A != 0) begin
      both_word = merge_word(b_word, bus.a_wdata, bus.a_be);
    end else begin
      both_word = merge_word(a_word, bus.b_wdata, bus.b_be);
    end
    if (!a_inr) begin
      a_rd_word = {DATA_WIDTH{1'b0}};
    end else if ((RDW_MODE != 0) && b_wr && same_addr) begin
      a_rd_word = b_word;
    end else begin
      a_rd_word = a_old;
    end
    if (!b_inr) begin
      b_rd_word = {DATA_WIDTH{1'b0}};
    end else if ((RDW_MODE != 0) && a_wr && same_addr) begin
      b_rd_word = a_word;
    end else begin
      b_rd_word = b_old;
    end
  end

  // Clear sequencer, array writes and collision flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_ptr     <= {ADDR_WIDTH{1'b0}};
      collision_r <= 1'b0;
    end else begin
      collision_r <= overlap;
      case (state)
        CLEAR: begin
          mem[clr_ptr] <= {DATA_WIDTH{1'b0}};
          if (clr_ptr == LAST_ADDR) begin
            state <= IDLE;
          end else begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          if (both_wr) begin
            mem[a_idx] <= both_word;
          end else begin
            if (a_wr) begin
              mem[a_idx] <= a_word;
            end
            if (b_wr) begin
              mem[b_idx] <= b_word;
            end
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign bus.collision = collision_r;
  assign bus.init_busy = (state == CLEAR);

  dpram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_rd),
    .in_err    (a_oor),
    .in_data   (a_rd_word),
    .out_valid (bus.a_rvalid),
    .out_err   (bus.a_err),
    .out_data  (bus.a_rdata)
  );

  dpram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_rd),
    .in_err    (b_oor),
    .in_data   (b_rd_word),
    .out_valid (bus.b_rvalid),
    .out_err   (bus.b_err),
    .out_data  (bus.b_rdata)
  );

endmodule

// File: tb/tb_dual_port_tx_ram_be.sv
// Directed bench: two instances share stimulus. dut0 = depth 16, latency 1, old-data RDW, A wins;
// dut1 = depth 12, latency 2, new-data RDW, B wins.
module tb_dual_port_tx_ram_be;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dual_port_tx_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if0 ();
  dual_port_tx_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if1 ();

  dual_port_tx_ram_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_DEPTH(16),
    .RD_LATENCY(1), .RDW_MODE(0), .PRIORITY_A(1)
  ) dut0 (.clk(clk), .reset(reset), .bus(if0));

  dual_port_tx_ram_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_DEPTH(12),
    .RD_LATENCY(2), .RDW_MODE(1), .PRIORITY_A(0)
  ) dut1 (.clk(clk), .reset(reset), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic we, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] wd);
    if0.a_en = en; if0.a_we = we; if0.a_be = be; if0.a_addr = addr; if0.a_wdata = wd;
    if1.a_en = en; if1.a_we = we; if1.a_be = be; if1.a_addr = addr; if1.a_wdata = wd;
  endtask

  task automatic drive_b(input logic en, input logic we, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] wd);
    if0.b_en = en; if0.b_we = we; if0.b_be = be; if0.b_addr = addr; if0.b_wdata = wd;
    if1.b_en = en; if1.b_we = we; if1.b_be = be; if1.b_addr = addr; if1.b_wdata = wd;
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    drive_b(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
  endtask

  // Runs a clear from reset release, hammering each DUT with requests while it is busy.
  task automatic run_clear(input int exp0, input int exp1);
    int   n0;
    int   n1;
    logic seen;
    n0   = 0;
    n1   = 0;
    seen = 1'b0;
    drive_a(1'b0, 1'b1, 4'hF, 4'd0, 32'hFFFF_FFFF);
    drive_b(1'b0, 1'b0, 4'h0, 4'd13, 32'h0);
    for (int i = 1; i <= 40; i++) begin
      if0.a_en = if0.init_busy; if0.b_en = if0.init_busy;
      if1.a_en = if1.init_busy; if1.b_en = if1.init_busy;
      step();
      seen = seen | if0.a_rvalid | if0.b_rvalid | if0.a_err | if0.b_err | if0.collision
                  | if1.a_rvalid | if1.b_rvalid | if1.a_err | if1.b_err | if1.collision;
      if (n0 == 0 && !if0.init_busy) n0 = i;
      if (n1 == 0 && !if1.init_busy) n1 = i;
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | if0.a_rvalid | if0.b_rvalid | if0.a_err | if0.b_err
                  | if1.a_rvalid | if1.b_rvalid | if1.a_err | if1.b_err;
    end
    chk("busy_len0", n0, exp0);
    chk("busy_len1", n1, exp1);
    chk("clr_quiet", {31'd0, seen}, 32'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_busy0", if0.init_busy, 32'd1);
    chk("rst_busy1", if1.init_busy, 32'd1);
    chk("rst_rvalid", if0.a_rvalid, 32'd0);
    chk("rst_rdata", if0.a_rdata, 32'd0);
    chk("rst_err", if0.b_err, 32'd0);
    chk("rst_coll", if1.collision, 32'd0);

    // 1: clear length and all-zero contents
    reset = 1'b0;
    run_clear(16, 12);
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
      step();
      chk("t1_d0_vld", if0.a_rvalid, 32'd1);
      chk("t1_d0_dat", if0.a_rdata, 32'd0);
      if (i > 0) begin
        chk("t1_d1_vld", if1.a_rvalid, 32'd1);
        chk("t1_d1_err", if1.a_err, ((i - 1) >= 12) ? 32'd1 : 32'd0);
      end else begin
        chk("t1_d1_lat", if1.a_rvalid, 32'd0);
      end
    end
    idle();
    step();
    chk("t1_d1_last_vld", if1.a_rvalid, 32'd1);
    chk("t1_d1_last_err", if1.a_err, 32'd1);
    chk("t1_d1_last_dat", if1.a_rdata, 32'd0);
    chk("t1_d0_end", if0.a_rvalid, 32'd0);

    // 2: full write then single-lane merge; latency per instance
    drive_a(1'b1, 1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF);
    step();
    chk("t2_wr_novld", if0.a_rvalid, 32'd0);
    drive_a(1'b1, 1'b1, 4'h2, 4'd3, 32'h0000_AA00);
    step();
    idle();
    drive_b(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    step();
    idle();
    chk("t2_d0_vld", if0.b_rvalid, 32'd1);
    chk("t2_d0_dat", if0.b_rdata, 32'hDEAD_AAEF);
    chk("t2_d1_early", if1.b_rvalid, 32'd0);
    step();
    chk("t2_d1_vld", if1.b_rvalid, 32'd1);
    chk("t2_d1_dat", if1.b_rdata, 32'hDEAD_AAEF);
    chk("t2_d0_pulse", if0.b_rvalid, 32'd0);
    chk("t2_d0_hold", if0.b_rdata, 32'hDEAD_AAEF);

    // 3: read-during-write on the other port
    drive_a(1'b1, 1'b1, 4'hF, 4'd5, 32'h1122_3344);
    drive_b(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    step();
    idle();
    chk("t3_d0_old", if0.b_rdata, 32'h0);
    step();
    chk("t3_d1_new", if1.b_rdata, 32'h1122_3344);

    // 4: same-address writes, overlapping lane 1
    drive_a(1'b1, 1'b1, 4'h3, 4'd7, 32'hAAAA_AAAA);
    drive_b(1'b1, 1'b1, 4'h6, 4'd7, 32'hBBBB_BBBB);
    step();
    idle();
    chk("t4_coll0", if0.collision, 32'd1);
    chk("t4_coll1", if1.collision, 32'd1);
    step();
    chk("t4_coll_once", if0.collision, 32'd0);
    // disjoint lanes on one address: both land, no collision
    drive_a(1'b1, 1'b1, 4'h1, 4'd8, 32'h0000_0011);
    drive_b(1'b1, 1'b1, 4'h8, 4'd8, 32'h4400_0000);
    step();
    idle();
    chk("t4_nocoll", if0.collision, 32'd0);
    drive_a(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    drive_b(1'b1, 1'b0, 4'h0, 4'd8, 32'h0);
    step();
    idle();
    chk("t4_d0_prioA", if0.a_rdata, 32'h00BB_AAAA);
    chk("t4_d0_disj", if0.b_rdata, 32'h4400_0011);
    step();
    chk("t4_d1_prioB", if1.a_rdata, 32'h00BB_BBAA);
    chk("t4_d1_disj", if1.b_rdata, 32'h4400_0011);

    // 5: out of range on the depth-12 instance
    drive_a(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
    step();
    idle();
    chk("t5_d0_inrange", if0.a_err, 32'd0);
    step();
    chk("t5_oor_err", if1.a_err, 32'd1);
    chk("t5_oor_vld", if1.a_rvalid, 32'd1);
    chk("t5_oor_dat", if1.a_rdata, 32'd0);
    step();
    chk("t5_err_pulse", if1.a_err, 32'd0);
    drive_a(1'b1, 1'b1, 4'hF, 4'd14, 32'hFFFF_FFFF);
    step();
    idle();
    step();
    chk("t5_wr_err", if1.a_err, 32'd1);
    chk("t5_wr_novld", if1.a_rvalid, 32'd0);
    drive_a(1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
    drive_b(1'b1, 1'b0, 4'h0, 4'd14, 32'h0);
    step();
    idle();
    chk("t5_d0_wr14", if0.b_rdata, 32'hFFFF_FFFF);
    step();
    chk("t5_d1_mem0", if1.a_rdata, 32'd0);

    // 6: reset mid-read flushes the pipe, reset mid-clear restarts the sweep
    drive_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    step();
    idle();
    reset = 1'b1;
    step();
    chk("t6_flush", if1.a_rvalid, 32'd0);
    chk("t6_busy", if0.init_busy, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_clear(16, 12);
    drive_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    step();
    idle();
    chk("t6_d0_cleared", if0.a_rdata, 32'd0);
    chk("t6_d0_vld", if0.a_rvalid, 32'd1);
    step();
    chk("t6_d1_cleared", if1.a_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
